// File: rtl/median_pkg.sv
// Shared types and compare-exchange helpers for the 3x3 streaming median filter.
package median_pkg;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } state_t;

   localparam int unsigned MEDIAN_LATENCY = 3;
   localparam int unsigned CX_W           = 32;

   // Compare-exchange halves; callers widen operands to CX_W and truncate the result.
   function automatic logic [CX_W-1:0] cx_min(input logic [CX_W-1:0] a, input logic [CX_W-1:0] b);
      return (a > b) ? b : a;
   endfunction

   function automatic logic [CX_W-1:0] cx_max(input logic [CX_W-1:0] a, input logic [CX_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/median_line_buffer.sv
// One-line pixel delay: combinational read of the old value, write of the new value on enable.
module median_line_buffer #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned PIX_W = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] wr_data,
   output logic [PIX_W-1:0] rd_data
);

   logic [PIX_W-1:0] mem [DEPTH];

   assign rd_data = mem[addr];

   always_ff @(posedge clk) begin
      if (en) mem[addr] <= wr_data;
   end

endmodule

// File: rtl/median3x3_stream.sv
// 3x3 streaming median over a raster pixel stream; emits interior pixels with a fixed 3-clock latency.
// Define MEDIAN_BYPASS_EN to add a 'bypass' input that forwards the unfiltered window centre.
module median3x3_stream
   import median_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 256,
   parameter int unsigned IMG_HEIGHT = 256,
   parameter int unsigned PIX_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pixel,
`ifdef MEDIAN_BYPASS_EN
   input  logic             bypass,
`endif
   output logic             out_valid,
   output logic             out_sof,
   output logic             out_eof,
   output logic [PIX_W-1:0] out_pixel
);

   localparam int unsigned COL_W = $clog2(IMG_WIDTH);
   localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
   localparam int unsigned LAT   = MEDIAN_LATENCY;

   typedef logic [8:0][PIX_W-1:0] win_t;

   function automatic logic [PIX_W-1:0] mn(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      return PIX_W'(cx_min(CX_W'(a), CX_W'(b)));
   endfunction

   function automatic logic [PIX_W-1:0] mx(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      return PIX_W'(cx_max(CX_W'(a), CX_W'(b)));
   endfunction

   function automatic win_t cxw(input win_t w, input logic [3:0] i, input logic [3:0] j);
      win_t o;
      o    = w;
      o[i] = mn(w[i], w[j]);
      o[j] = mx(w[i], w[j]);
      return o;
   endfunction

   state_t           state;
   logic [COL_W-1:0] col, pos_c;
   logic [ROW_W-1:0] row, pos_r;
   logic             acc, at_eol, at_eof, emit, first;
   logic [PIX_W-1:0] lb1, lb2;
   win_t             win, s1, s1_d;
   logic [PIX_W-1:0] s2_p2, s2_p4, s2_p6, s2_p7;
   logic [PIX_W-1:0] s2_p3_d, s2_p4a_d, s2_p5_d;
   logic [PIX_W-1:0] m_a, m_lo, m_hi, m_c, med, res;
   logic [LAT-1:0]   vld, sof_p, eof_p;

   // Accept/position decode; an in_sof pixel always sits at (0,0).
   always_comb begin
      acc    = in_valid && ((state == ACTIVE) || in_sof);
      pos_c  = in_sof ? '0 : col;
      pos_r  = in_sof ? '0 : row;
      at_eol = (pos_c == COL_W'(IMG_WIDTH - 1));
      at_eof = at_eol && (pos_r == ROW_W'(IMG_HEIGHT - 1));
      emit   = (pos_r >= ROW_W'(2)) && (pos_c >= COL_W'(2));
      first  = (pos_r == ROW_W'(2)) && (pos_c == COL_W'(2));
   end

   median_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
      .clk(clk), .en(acc), .addr(pos_c), .wr_data(in_pixel), .rd_data(lb1)
   );

   median_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb2 (
      .clk(clk), .en(acc), .addr(pos_c), .wr_data(lb1), .rd_data(lb2)
   );

   // Sorting network, stage 1: sort each row.
   always_comb begin
      s1_d = win;
      s1_d = cxw(s1_d, 4'd1, 4'd2);
      s1_d = cxw(s1_d, 4'd4, 4'd5);
      s1_d = cxw(s1_d, 4'd7, 4'd8);
      s1_d = cxw(s1_d, 4'd0, 4'd1);
      s1_d = cxw(s1_d, 4'd3, 4'd4);
      s1_d = cxw(s1_d, 4'd6, 4'd7);
      s1_d = cxw(s1_d, 4'd1, 4'd2);
      s1_d = cxw(s1_d, 4'd4, 4'd5);
      s1_d = cxw(s1_d, 4'd7, 4'd8);
   end

   // Stage 2 keeps only the four lanes the final merge needs.
   always_comb begin
      s2_p3_d  = mx(s1[0], s1[3]);
      s2_p5_d  = mn(s1[5], s1[8]);
      s2_p4a_d = mn(s1[4], s1[7]);
   end

   // Stage 3 (into the output register): four exchanges reduce to the median.
   always_comb begin
      m_a  = mn(s2_p4, s2_p7);
      m_lo = mn(m_a, s2_p2);
      m_hi = mx(m_a, s2_p2);
      m_c  = mx(s2_p6, m_lo);
      med  = mn(m_c, m_hi);
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         win[0] <= win[1]; win[1] <= win[2]; win[2] <= lb2;
         win[3] <= win[4]; win[4] <= win[5]; win[5] <= lb1;
         win[6] <= win[7]; win[7] <= win[8]; win[8] <= in_pixel;
      end
      s1    <= s1_d;
      s2_p2 <= mn(s1[2], s2_p5_d);
      s2_p4 <= mx(s1[1], s2_p4a_d);
      s2_p6 <= mx(s2_p3_d, s1[6]);
      s2_p7 <= mx(s1[4], s1[7]);
   end

`ifdef MEDIAN_BYPASS_EN
   logic             byp0, byp1, byp2;
   logic [PIX_W-1:0] ctr1, ctr2;

   always_ff @(posedge clk) begin
      if (acc) byp0 <= bypass;
      byp1 <= byp0;
      byp2 <= byp1;
      ctr1 <= win[4];
      ctr2 <= ctr1;
   end

   always_comb res = byp2 ? ctr2 : med;
`else
   always_comb res = med;
`endif

   // Frame FSM, position counters, marker pipeline and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WAIT_SOF;
         col       <= '0;
         row       <= '0;
         vld       <= '0;
         sof_p     <= '0;
         eof_p     <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         out_pixel <= '0;
      end else begin
         vld       <= {vld[LAT-2:0],   acc && emit};
         sof_p     <= {sof_p[LAT-2:0], acc && first};
         eof_p     <= {eof_p[LAT-2:0], acc && at_eof};
         out_valid <= vld[LAT-1];
         out_sof   <= sof_p[LAT-1];
         out_eof   <= eof_p[LAT-1];
         if (vld[LAT-1]) out_pixel <= res;
         if (acc) begin
            if (at_eof) begin
               state <= WAIT_SOF;
               col   <= '0;
               row   <= '0;
            end else begin
               state <= ACTIVE;
               if (at_eol) begin
                  col <= '0;
                  row <= pos_r + ROW_W'(1);
               end else begin
                  col <= pos_c + COL_W'(1);
                  row <= pos_r;
               end
            end
         end
      end
   end

endmodule
